// File: rtl/stack_pkg.sv
// Shared types and constants for the operand-stack spill/fill controller.
package stack_pkg;

   localparam int          WIDTH      = 35;
   localparam logic [31:0] STACK_BASE = 32'h0010_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SPILL = 2'd1,
      FILL  = 2'd2
   } fsm_e;

   // Byte address of a spilled stack slot (one 32-bit word per slot).
   function automatic logic [31:0] slot_addr(input logic [31:0] base, input logic [15:0] slot);
      return base + {14'd0, slot, 2'b00};
   endfunction

endpackage

// File: rtl/stack_ring.sv
// On-chip ring holding the top entries of the operand stack.
// Per cycle: bottom insert/remove (memory traffic), then pop-n from top, then push.
module stack_ring
   import stack_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = WIDTH,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          ins_bot,
   input  logic [W-1:0]  ins_data,
   input  logic          rem_bot,
   input  logic [10:0]   pop_n,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   output logic [W-1:0]  top0,
   output logic [W-1:0]  top1,
   output logic [W-1:0]  bot,
   output logic [CW-1:0] cnt,
   output logic [CW-1:0] cnt_ack,
   output logic          push_drop
);

   localparam int IW = $clog2(DEPTH);

   logic [W-1:0]  ring_q [DEPTH];
   logic [W-1:0]  ring_d [DEPTH];
   logic [IW-1:0] top_q, top_d, bot_idx;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [16:0]   c1, take, c2;

   // Bottom sits cnt-1 slots below top, modulo the ring size.
   assign bot_idx = top_q - IW'(cnt_q) + IW'(1);

   // Apply memory effect, then pop (clamped to what the ring holds), then push.
   always_comb begin
      ring_d    = ring_q;
      top_d     = top_q;
      push_drop = 1'b0;
      c1        = 17'(cnt_q) + 17'(ins_bot) - 17'(rem_bot);
      if (ins_bot) ring_d[bot_idx - IW'(1)] = ins_data;
      take  = ({6'd0, pop_n} <= c1) ? {6'd0, pop_n} : c1;
      c2    = c1 - take;
      top_d = top_q - IW'(take);
      if (push) begin
         if (c2 < 17'(DEPTH)) begin
            top_d         = top_d + IW'(1);
            ring_d[top_d] = push_data;
            c2            = c2 + 17'd1;
         end else begin
            push_drop = 1'b1;
         end
      end
      cnt_d = CW'(c2);
   end

   // Ring storage and pointers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
         top_q <= '0;
         cnt_q <= '0;
      end else begin
         ring_q <= ring_d;
         top_q  <= top_d;
         cnt_q  <= cnt_d;
      end
   end

   assign top0    = (cnt_q != '0)       ? ring_q[top_q]          : '0;
   assign top1    = (cnt_q >= CW'(2))   ? ring_q[top_q - IW'(1)] : '0;
   assign bot     = ring_q[bot_idx];
   assign cnt     = cnt_q;
   assign cnt_ack = CW'(c1);

endmodule

// File: rtl/stack_spill_ctl.sv
// Operand-stack controller: keeps the top of stack on chip, spills the
// bottom entry to memory above the high-water mark and fills below the low one.
module stack_spill_ctl
   import stack_pkg::*;
#(
   parameter int          DEPTH      = 8,
   parameter int          WIDTH      = stack_pkg::WIDTH,
   parameter int          HI_WATER   = 6,
   parameter int          LO_WATER   = 2,
   parameter int          MEM_DEPTH  = 4096,
   parameter logic [31:0] STACK_BASE = stack_pkg::STACK_BASE
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             st__push_5a,
   input  logic [10:0]      st__to_pop_5a,
   input  logic [WIDTH-1:0] st__to_push_5a,
   output logic [WIDTH-1:0] st__top_0,
   output logic [WIDTH-1:0] st__top_1,
   output logic             st__busy,
   output logic [15:0]      st__depth,
   output logic             st__underflow,
   output logic             st__overflow,
   output logic             mem__req,
   output logic             mem__we,
   output logic [31:0]      mem__addr,
   output logic [WIDTH-1:0] mem__wdata,
   input  logic [WIDTH-1:0] mem__rdata,
   input  logic             mem__ack
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int MW = $clog2(MEM_DEPTH + 1);

   fsm_e             state_q, state_d;
   logic [MW-1:0]    mem_cnt_q, mem_cnt_d;
   logic             unf_q, unf_d, ovf_q, ovf_d;
   logic             req_q, req_d, we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;

   logic [CW-1:0]    cnt, cnt_ack;
   logic [WIDTH-1:0] bot;
   logic             push_drop;
   logic [16:0]      cnt17, mem17, ack17, n17, m;
   logic             spill_c, fill_c, full_c, spill_take, fill_take;

   assign cnt17 = 17'(cnt);
   assign mem17 = 17'(mem_cnt_q);
   assign ack17 = 17'(cnt_ack);
   assign n17   = {6'd0, st__to_pop_5a};

   assign spill_c = (cnt17 >= 17'(HI_WATER)) && (mem17 < 17'(MEM_DEPTH));
   assign fill_c  = (cnt17 < 17'(LO_WATER)) && (mem17 != '0);
   assign full_c  = (cnt17 >= 17'(HI_WATER)) && (mem17 == 17'(MEM_DEPTH));

   // An ack whose entry was popped away meanwhile (spill: ring empty; fill:
   // memory drained) is dropped rather than corrupting the stack.
   assign spill_take = (state_q == SPILL) && mem__ack && (cnt17 != '0);
   assign fill_take  = (state_q == FILL) && mem__ack && (mem17 != '0) && (cnt17 < 17'(DEPTH));

   stack_ring #(.DEPTH(DEPTH), .W(WIDTH), .CW(CW)) u_ring (
      .clk       (clk),
      .rst_b     (rst_b),
      .ins_bot   (fill_take),
      .ins_data  (mem__rdata),
      .rem_bot   (spill_take),
      .pop_n     (st__to_pop_5a),
      .push      (st__push_5a),
      .push_data (st__to_push_5a),
      .top0      (st__top_0),
      .top1      (st__top_1),
      .bot       (bot),
      .cnt       (cnt),
      .cnt_ack   (cnt_ack),
      .push_drop (push_drop)
   );

   // Memory count and sticky flags: ack effect, then pops that reach past the ring.
   always_comb begin
      m     = mem17;
      unf_d = unf_q;
      ovf_d = ovf_q | push_drop | ((state_q == IDLE) && full_c);
      if (spill_take) m = m + 17'd1;
      if (fill_take)  m = m - 17'd1;
      if (n17 > ack17) begin
         if ((n17 - ack17) <= m) begin
            m = m - (n17 - ack17);
         end else begin
            unf_d = 1'b1;
            m     = '0;
         end
      end
      mem_cnt_d = MW'(m);
   end

   // Spill/fill sequencer; request fields are latched on entry and held until ack.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (spill_c) begin
               state_d = SPILL;
               req_d   = 1'b1;
               we_d    = 1'b1;
               addr_d  = slot_addr(STACK_BASE, 16'(mem_cnt_q));
               wdata_d = bot;
            end else if (fill_c) begin
               state_d = FILL;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = slot_addr(STACK_BASE, 16'(mem17 - 17'd1));
               wdata_d = '0;
            end
         end
         SPILL, FILL: begin
            if (mem__ack) begin
               state_d = IDLE;
               req_d   = 1'b0;
               we_d    = 1'b0;
               addr_d  = '0;
               wdata_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Controller state registers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= IDLE;
         mem_cnt_q <= '0;
         unf_q     <= 1'b0;
         ovf_q     <= 1'b0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         mem_cnt_q <= mem_cnt_d;
         unf_q     <= unf_d;
         ovf_q     <= ovf_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
      end
   end

   assign st__busy      = (state_q != IDLE) | spill_c | fill_c;
   assign st__depth     = 16'(cnt17 + mem17);
   assign st__underflow = unf_q;
   assign st__overflow  = ovf_q;
   assign mem__req      = req_q;
   assign mem__we       = we_q;
   assign mem__addr     = addr_q;
   assign mem__wdata    = wdata_q;

endmodule

// File: tb/tb_stack_spill_ctl.sv
// Bench for stack_spill_ctl: directed scenarios plus random push/pop traffic
// checked against a queue model of the whole stack and its on-chip split.
module tb_stack_spill_ctl;
   import stack_pkg::*;

   localparam int          DEPTH = 8;
   localparam int          W     = 35;
   localparam int          HI    = 6;
   localparam int          LO    = 2;
   localparam int          MEMD  = 4096;
   localparam logic [31:0] BASE  = 32'h0010_0000;

   logic          clk, rst_b;
   logic          st__push_5a;
   logic [10:0]   st__to_pop_5a;
   logic [W-1:0]  st__to_push_5a;
   logic [W-1:0]  st__top_0, st__top_1;
   logic          st__busy;
   logic [15:0]   st__depth;
   logic          st__underflow, st__overflow;
   logic          mem__req, mem__we;
   logic [31:0]   mem__addr;
   logic [W-1:0]  mem__wdata, mem__rdata;
   logic          mem__ack;

   stack_spill_ctl #(
      .DEPTH(DEPTH), .WIDTH(W), .HI_WATER(HI), .LO_WATER(LO),
      .MEM_DEPTH(MEMD), .STACK_BASE(BASE)
   ) dut (
      .clk(clk), .rst_b(rst_b),
      .st__push_5a(st__push_5a), .st__to_pop_5a(st__to_pop_5a), .st__to_push_5a(st__to_push_5a),
      .st__top_0(st__top_0), .st__top_1(st__top_1), .st__busy(st__busy), .st__depth(st__depth),
      .st__underflow(st__underflow), .st__overflow(st__overflow),
      .mem__req(mem__req), .mem__we(mem__we), .mem__addr(mem__addr), .mem__wdata(mem__wdata),
      .mem__rdata(mem__rdata), .mem__ack(mem__ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: full stack as a queue (bottom at index 0), oc = entries held on chip.
   logic [W-1:0] stk[$];
   int           oc;
   bit           unf_m, ovf_m, pend, pend_we;
   logic [31:0]  pend_addr;
   logic [W-1:0] pend_wdata;
   logic [W-1:0] mem [0:4095];
   int           ack_dly, wait_cnt;
   bit           man_ack, force_ack;
   int           n_cmp, n_bad;

   task automatic model_edge(input bit ack);
      int msz, n;
      msz = stk.size() - oc;
      if (pend) begin
         if (ack) begin
            if (pend_we) begin
               if (oc > 0) oc--;
            end else if (msz > 0 && oc < DEPTH) oc++;
            pend = 0;
         end
      end else if (oc >= HI && msz < MEMD) begin
         pend = 1; pend_we = 1; pend_addr = BASE + 32'(4 * msz); pend_wdata = stk[msz];
      end else if (oc < LO && msz > 0) begin
         pend = 1; pend_we = 0; pend_addr = BASE + 32'(4 * (msz - 1)); pend_wdata = '0;
      end else if (oc >= HI && msz == MEMD) ovf_m = 1;
      n = int'(st__to_pop_5a);
      if (n <= oc) begin
         oc -= n;
         repeat (n) void'(stk.pop_back());
      end else if (n <= stk.size()) begin
         repeat (n) void'(stk.pop_back());
         oc = 0;
      end else begin
         unf_m = 1; stk.delete(); oc = 0;
      end
      if (st__push_5a) begin
         if (oc == DEPTH) ovf_m = 1;
         else begin stk.push_back(st__to_push_5a); oc++; end
      end
   endtask

   // One clock: memory responder decides on ack, edge, model update, inputs cleared.
   task automatic tick();
      bit ack;
      int slot;
      ack = 0;
      if (mem__req === 1'b1) begin
         if (man_ack) ack = force_ack;
         else if (wait_cnt <= 0) ack = 1;
         else wait_cnt--;
      end else wait_cnt = ack_dly;
      if (ack) begin
         slot = int'((mem__addr - BASE) >> 2) & 4095;
         if (mem__we) mem[slot] = mem__wdata;
         else mem__rdata = mem[slot];
      end
      mem__ack = ack;
      @(posedge clk);
      model_edge(ack);
      #1;
      st__push_5a = 1'b0; st__to_pop_5a = '0; mem__ack = 1'b0; force_ack = 0;
      @(negedge clk);
   endtask

   task automatic do_push(input logic [W-1:0] d);
      st__push_5a = 1'b1; st__to_push_5a = d; tick();
   endtask

   task automatic do_pop(input int n);
      st__to_pop_5a = 11'(n); tick();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && st__busy; i++) tick();
      n_cmp++; if (st__busy !== 1'b0) begin n_bad++; $display("FAIL idle_timeout busy=%b exp 0", st__busy); end
   endtask

   task automatic do_reset();
      rst_b = 1'b0; st__push_5a = 1'b0; st__to_pop_5a = '0; mem__ack = 1'b0;
      stk.delete(); oc = 0; unf_m = 0; ovf_m = 0; pend = 0; man_ack = 0; force_ack = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_b = 1'b1; wait_cnt = 0;
   endtask

   task automatic test_reset();
      #1 rst_b = 1'b0;
      #2;
      n_cmp++;
      if ({st__top_0, st__top_1, st__busy, st__depth, st__underflow, st__overflow,
           mem__req, mem__we, mem__addr, mem__wdata} !== '0) begin
         n_bad++; $display("FAIL reset_outputs top0=%h depth=%0d req=%b exp all 0", st__top_0, st__depth, mem__req);
      end
      do_reset();
   endtask

   task automatic test_push3();
      do_reset();
      do_push(35'h1); do_push(35'h2); do_push(35'h3);
      n_cmp++; if (st__top_0 !== 35'h3) begin n_bad++; $display("FAIL push3_top0 got %h exp 3", st__top_0); end
      n_cmp++; if (st__top_1 !== 35'h2) begin n_bad++; $display("FAIL push3_top1 got %h exp 2", st__top_1); end
      n_cmp++; if (st__depth !== 16'd3) begin n_bad++; $display("FAIL push3_depth got %0d exp 3", st__depth); end
      n_cmp++; if ({st__busy, mem__req} !== 2'b00) begin n_bad++; $display("FAIL push3_quiet busy/req got %b%b exp 00", st__busy, mem__req); end
   endtask

   task automatic test_spill_fill();
      logic [W-1:0] d [6];
      do_reset();
      ack_dly = 3;
      d[0] = 35'hA;
      for (int i = 1; i < 6; i++) d[i] = W'({$urandom(), $urandom()});
      for (int i = 0; i < 6; i++) do_push(d[i]);
      n_cmp++; if ({st__busy, mem__req} !== 2'b10) begin n_bad++; $display("FAIL spill_busy_at6 busy/req got %b%b exp 10", st__busy, mem__req); end
      tick();
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if ({mem__req, mem__we, mem__addr, mem__wdata} !== {1'b1, 1'b1, 32'h0010_0000, 35'hA}) begin
            n_bad++; $display("FAIL spill_req_hold cyc%0d req=%b addr=%h wdata=%h exp 1/00100000/A", k, mem__req, mem__addr, mem__wdata);
         end
         if (k < 3) tick();
      end
      tick();
      n_cmp++; if ({mem__req, st__busy} !== 2'b00) begin n_bad++; $display("FAIL spill_done req/busy got %b%b exp 00", mem__req, st__busy); end
      n_cmp++; if (st__depth !== 16'd6) begin n_bad++; $display("FAIL spill_depth got %0d exp 6", st__depth); end
      do_pop(3);
      n_cmp++; if ({st__top_0, st__depth, st__busy} !== {d[2], 16'd3, 1'b0}) begin n_bad++; $display("FAIL pop3 top0=%h depth=%0d busy=%b exp %h 3 0", st__top_0, st__depth, st__busy, d[2]); end
      do_pop(1);
      tick();
      n_cmp++; if ({mem__req, mem__we, mem__addr} !== {1'b1, 1'b0, 32'h0010_0000}) begin n_bad++; $display("FAIL fill_req req=%b we=%b addr=%h exp 1 0 00100000", mem__req, mem__we, mem__addr); end
      wait_idle();
      n_cmp++; if ({st__top_0, st__top_1, st__depth} !== {d[1], 35'hA, 16'd2}) begin n_bad++; $display("FAIL fill_done top0=%h top1=%h depth=%0d exp %h A 2", st__top_0, st__top_1, st__depth, d[1]); end
   endtask

   task automatic test_fill_pop_push();
      do_reset();
      ack_dly = 0;
      do_push(35'hA);
      for (int i = 1; i < 6; i++) do_push(W'(i + 35'h100));
      wait_idle();
      do_pop(3);
      man_ack = 1;
      do_pop(1);
      tick();
      n_cmp++; if ({mem__req, mem__we} !== 2'b10) begin n_bad++; $display("FAIL fpp_req req/we got %b%b exp 10", mem__req, mem__we); end
      force_ack = 1; st__to_pop_5a = 11'd1; st__push_5a = 1'b1; st__to_push_5a = 35'h7;
      tick();
      man_ack = 0;
      n_cmp++; if ({st__top_0, st__top_1, st__depth} !== {35'h7, 35'hA, 16'd2}) begin n_bad++; $display("FAIL fpp_result top0=%h top1=%h depth=%0d exp 7 A 2", st__top_0, st__top_1, st__depth); end
   endtask

   task automatic test_pop_past_ring_and_underflow();
      do_reset();
      ack_dly = 0;
      for (int i = 0; i < 6; i++) do_push(W'(i + 35'h200));
      wait_idle();
      do_push(35'h206);
      wait_idle();
      do_pop(2);
      n_cmp++; if ({st__depth, st__busy} !== {16'd5, 1'b0}) begin n_bad++; $display("FAIL c3m2 depth=%0d busy=%b exp 5 0", st__depth, st__busy); end
      do_pop(4);
      n_cmp++; if ({st__depth, st__underflow, mem__req, st__busy} !== {16'd1, 1'b0, 1'b0, 1'b1}) begin
         n_bad++; $display("FAIL pop_into_mem depth=%0d unf=%b req=%b busy=%b exp 1 0 0 1", st__depth, st__underflow, mem__req, st__busy);
      end
      wait_idle();
      n_cmp++; if ({st__top_0, st__top_1} !== {35'h200, 35'h0}) begin n_bad++; $display("FAIL refill_top top0=%h top1=%h exp 200 0", st__top_0, st__top_1); end
      do_push(35'h55);
      do_pop(5);
      tick();
      n_cmp++; if ({st__underflow, st__depth, st__top_0} !== {1'b1, 16'd0, 35'h0}) begin n_bad++; $display("FAIL underflow unf=%b depth=%0d top0=%h exp 1 0 0", st__underflow, st__depth, st__top_0); end
      rst_b = 1'b0; #1;
      n_cmp++; if ({st__underflow, st__overflow, st__depth, st__top_0, mem__req} !== '0) begin n_bad++; $display("FAIL reset_clears unf=%b ovf=%b depth=%0d exp 0", st__underflow, st__overflow, st__depth); end
      do_reset();
   endtask

   task automatic test_overflow_abandon();
      do_reset();
      man_ack = 1;
      for (int i = 1; i <= 9; i++) do_push(W'(i + 35'h300));
      n_cmp++; if ({st__overflow, st__depth, st__top_0, mem__req} !== {1'b1, 16'd8, 35'h308, 1'b1}) begin
         n_bad++; $display("FAIL overflow ovf=%b depth=%0d top0=%h req=%b exp 1 8 308 1", st__overflow, st__depth, st__top_0, mem__req);
      end
      rst_b = 1'b0; #1;
      n_cmp++; if ({mem__req, st__overflow} !== 2'b00) begin n_bad++; $display("FAIL async_abandon req=%b ovf=%b exp 0 0", mem__req, st__overflow); end
      do_reset();
   endtask

   task automatic test_random();
      logic [W-1:0] e0, e1;
      int msz, r;
      bit ebusy;
      do_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         ack_dly = $urandom_range(3, 0);
         if (!st__busy) begin
            r = $urandom_range(99, 0);
            if (r < 55) begin st__push_5a = 1'b1; st__to_push_5a = W'({$urandom(), $urandom()}); end
            else if (r < 85) st__to_pop_5a = 11'($urandom_range(3, 1));
            else if (r < 92) begin st__to_pop_5a = 11'd1; st__push_5a = 1'b1; st__to_push_5a = W'($urandom()); end
            else if (r < 93) st__to_pop_5a = 11'($urandom_range(20, 0));
         end
         tick();
         msz   = stk.size() - oc;
         e0    = (oc >= 1) ? stk[stk.size() - 1] : '0;
         e1    = (oc >= 2) ? stk[stk.size() - 2] : '0;
         ebusy = pend || (oc >= HI && msz < MEMD) || (oc < LO && msz > 0);
         n_cmp++; if (st__top_0 !== e0) begin n_bad++; $display("FAIL rnd_top0 cyc%0d got %h exp %h", cyc, st__top_0, e0); end
         n_cmp++; if (st__top_1 !== e1) begin n_bad++; $display("FAIL rnd_top1 cyc%0d got %h exp %h", cyc, st__top_1, e1); end
         n_cmp++; if (st__depth !== 16'(stk.size())) begin n_bad++; $display("FAIL rnd_depth cyc%0d got %0d exp %0d", cyc, st__depth, stk.size()); end
         n_cmp++; if ({st__busy, mem__req, st__underflow, st__overflow} !== {ebusy, pend, unf_m, ovf_m}) begin
            n_bad++; $display("FAIL rnd_flags cyc%0d busy/req/unf/ovf got %b%b%b%b exp %b%b%b%b", cyc,
                              st__busy, mem__req, st__underflow, st__overflow, ebusy, pend, unf_m, ovf_m);
         end
         if (pend) begin
            n_cmp++;
            if ({mem__we, mem__addr, mem__wdata} !== {pend_we, pend_addr, pend_wdata}) begin
               n_bad++; $display("FAIL rnd_req cyc%0d we=%b addr=%h wdata=%h exp %b %h %h", cyc,
                                 mem__we, mem__addr, mem__wdata, pend_we, pend_addr, pend_wdata);
            end
         end
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      rst_b = 1'b1; st__push_5a = 1'b0; st__to_pop_5a = '0; st__to_push_5a = '0;
      mem__rdata = '0; mem__ack = 1'b0;
      ack_dly = 0; wait_cnt = 0; man_ack = 0; force_ack = 0;
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      test_reset();
      test_push3();
      test_spill_fill();
      test_fill_pop_push();
      test_pop_past_ring_and_underflow();
      test_overflow_abandon();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
